// File: rtl/regbank_step_console.sv
// Button-stepped console for a small register file and ALU: switch commands, chunked
// immediate loads and register read-back, with wide results paged to the LEDs.
module regbank_step_console #(
  parameter int DATA_W  = 32,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in,
  input  logic             btn,
  output logic [OUT_W-1:0] out,
  output logic [1:0]       state_o,
  output logic             wr_en_o,
  output logic             err
);

  localparam int NREG = 2 ** AW;
  localparam int SW   = $clog2(DATA_W);
  localparam int NIN  = DATA_W / IN_W;
  localparam int NOUT = DATA_W / OUT_W;
  localparam int KW   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int IW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [KW-1:0] LAST_K   = KW'(NIN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NOUT - 1);

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_FN   = 2'd1,
    ST_IMM  = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  state_t              r_state, w_nextState;
  logic                r_btnQ;
  logic                w_step;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [AW-1:0]       r_rs, r_rt, r_rd;
  logic [DATA_W-1:0]   r_acc, w_accNext;
  logic [KW-1:0]       r_k;
  logic [IW-1:0]       r_idx, w_idxNext;
  logic [DATA_W-1:0]   r_result;
  logic [OUT_W-1:0]    r_out;
  logic                r_wrEn;
  logic                r_err;

  logic [1:0]          w_mode;
  logic [AW-1:0]       w_fa, w_fb, w_fc;
  logic [3:0]          w_op;
  logic [SW-1:0]       w_shamt;
  logic [DATA_W-1:0]   w_opA, w_opB, w_readA, w_aluRes;
  logic                w_rdIsZero;

  assign w_mode  = in[IN_W-1 -: 2];
  assign w_fa    = in[IN_W-3 -: AW];
  assign w_fb    = in[IN_W-3-AW -: AW];
  assign w_fc    = in[IN_W-3-2*AW -: AW];
  assign w_op    = in[IN_W-1 -: 4];
  assign w_shamt = in[SW-1:0];

  // The edge detector keeps sampling through reset so a button held across release is ignored
  always_ff @(posedge clk) begin
    r_btnQ <= btn;
  end

  assign w_step     = btn & ~r_btnQ;
  assign w_rdIsZero = (ZERO_R0 != 0) && (r_rd == '0);
  assign w_opA      = ((ZERO_R0 != 0) && (r_rs == '0)) ? '0 : r_regs[r_rs];
  assign w_opB      = ((ZERO_R0 != 0) && (r_rt == '0)) ? '0 : r_regs[r_rt];
  assign w_readA    = ((ZERO_R0 != 0) && (w_fa == '0)) ? '0 : r_regs[w_fa];
  assign w_idxNext  = r_idx + 1'b1;

  always_comb begin
    w_accNext = r_acc;
    w_accNext[r_k*IN_W +: IN_W] = in;
  end

  always_comb begin
    w_aluRes = w_opA;
    case (w_op)
      4'd0:    w_aluRes = w_opA + w_opB;
      4'd1:    w_aluRes = w_opA - w_opB;
      4'd2:    w_aluRes = w_opA & w_opB;
      4'd3:    w_aluRes = w_opA | w_opB;
      4'd4:    w_aluRes = w_opA ^ w_opB;
      4'd5:    w_aluRes = ~(w_opA | w_opB);
      4'd6:    w_aluRes = w_opA << w_shamt;
      4'd7:    w_aluRes = w_opA >> w_shamt;
      4'd8:    w_aluRes = $unsigned($signed(w_opA) >>> w_shamt);
      4'd9:    w_aluRes = {{(DATA_W-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
      4'd10:   w_aluRes = w_opA << w_opB[SW-1:0];
      default: w_aluRes = w_opA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CMD;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_step) begin
      case (r_state)
        ST_CMD: begin
          case (w_mode)
            2'b00:   w_nextState = ST_FN;
            2'b01:   w_nextState = ST_IMM;
            2'b10:   w_nextState = ST_SHOW;
            default: w_nextState = ST_CMD;
          endcase
        end
        ST_FN:   w_nextState = ST_SHOW;
        ST_IMM:  if (r_k == LAST_K) w_nextState = ST_SHOW;
        ST_SHOW: if (r_idx == LAST_IDX) w_nextState = ST_CMD;
        default: w_nextState = ST_CMD;
      endcase
    end
  end

  // Operands come from the pre-edge register values, so aliased rs/rt/rd read the old contents
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_out    <= OUT_W'(1);
      r_wrEn   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wrEn <= 1'b0;
      if (w_step) begin
        case (r_state)
          ST_CMD: begin
            case (w_mode)
              2'b00: begin
                r_rs  <= w_fa;
                r_rt  <= w_fb;
                r_rd  <= w_fc;
                r_out <= OUT_W'(2);
              end
              2'b01: begin
                r_rd  <= w_fa;
                r_acc <= '0;
                r_k   <= '0;
                r_out <= OUT_W'(4);
              end
              2'b10: begin
                r_result <= w_readA;
                r_idx    <= '0;
                r_out    <= w_readA[OUT_W-1:0];
              end
              default: r_err <= 1'b1;
            endcase
          end
          ST_FN: begin
            if (!w_rdIsZero) r_regs[r_rd] <= w_aluRes;
            r_wrEn   <= 1'b1;
            r_result <= w_aluRes;
            r_idx    <= '0;
            r_out    <= w_aluRes[OUT_W-1:0];
          end
          ST_IMM: begin
            r_acc <= w_accNext;
            if (r_k == LAST_K) begin
              if (!w_rdIsZero) r_regs[r_rd] <= w_accNext;
              r_wrEn   <= 1'b1;
              r_result <= w_accNext;
              r_idx    <= '0;
              r_out    <= w_accNext[OUT_W-1:0];
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          ST_SHOW: begin
            if (r_idx == LAST_IDX) begin
              r_out <= OUT_W'(1);
            end else begin
              r_idx <= w_idxNext;
              r_out <= r_result[w_idxNext*OUT_W +: OUT_W];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out     = r_out;
  assign state_o = r_state;
  assign wr_en_o = r_wrEn;
  assign err     = r_err;

endmodule

// File: doc/regbank_step_console.md
Name: regbank_step_console

Overview:
Parametrised successor to the board-level register-bank stepper. It is a button-stepped console for a self-contained register file and ALU: switches (`in`) supply commands and operands, and each debounced `btn` rising edge advances one step. There are three modes: ALU operation, multi-chunk load-immediate, and register read-back. Wide results are paged to the LEDs (`out`) one slice per step. It sits at the top of the FPGA lab build, between the board I/O and the datapath.

Parameters:
DATA_W, 32, register and ALU width; must be a multiple of IN_W and of OUT_W.
IN_W, 16, switch width; must satisfy IN_W >= 2+3*AW and IN_W >= 4+SW.
OUT_W, 16, LED width; must be >= 4.
AW, 4, register address width; NREG = 2**AW.
ZERO_R0, 1, when 1, writes to r0 are discarded and reads of r0 return 0.
Derived: SW = clog2(DATA_W) (shamt width); NIN = DATA_W/IN_W; NOUT = DATA_W/OUT_W.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in  input  IN_W  switch inputs.
btn  input  1  step button, already synchronised to clk.
out  output  OUT_W  LED display.
state_o  output  2  current state: CMD=0, FN=1, IMM=2, SHOW=3.
wr_en_o  output  1  one-cycle pulse on the cycle a register is written.
err  output  1  sticky flag: a reserved mode was issued.

Behaviour:
- Step detection
  - step = btn & ~btn_q; btn_q <= btn every cycle, including during reset.
  - A button held across reset release therefore produces no step.
  - A held button produces exactly one step.
  - All actions below occur on the clock edge where step=1; outputs are registered and visible the next cycle.
- Reset
  - state=CMD, out=1, wr_en_o=0, err=0, all NREG registers=0.
  - All internal latches and counters are cleared.
  - Reset overrides step in the same cycle and aborts any operation in progress; no partial write occurs.
- CMD (out=1)
  - Fields: mode=in[IN_W-1:IN_W-2], a=next AW bits, b=next AW bits, c=next AW bits.
  - mode 00 (ALU): latch rs=a, rt=b, rd=c -> FN.
  - mode 01 (LOADI): latch rd=a, clear accumulator and chunk index k -> IMM.
  - mode 10 (READ): result=reg[a] -> SHOW with slice index 0.
  - mode 11: err<=1, stay in CMD.
- FN (out=2)
  - Fields: op=in[IN_W-1:IN_W-4], shamt=in[SW-1:0].
  - Result is computed from reg[rs]/reg[rt] and written to reg[rd] on the same edge; wr_en_o pulses one cycle; -> SHOW.
  - Ops: 0 ADD, 1 SUB (rs-rt), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL rs by shamt, 7 SRL rs by shamt, 8 SRA rs by shamt, 9 SLT signed (result 1/0), 10 SLLV rs by rt[SW-1:0].
  - ops 11-15: result = reg[rs].
  - Arithmetic wraps modulo 2**DATA_W; no flags.
- IMM (out=4)
  - Each step stores in into chunk k of the accumulator, least-significant chunk first.
  - On chunk NIN-1: write reg[rd], pulse wr_en_o, result=accumulated value -> SHOW.
- SHOW
  - out=result[idx*OUT_W +: OUT_W], with idx starting at 0.
  - Each step increments idx; the step at idx=NOUT-1 -> CMD (out=1).
- r0 with ZERO_R0=1
  - A write to r0 is discarded, but wr_en_o still pulses and SHOW displays the computed value.
  - Reading r0 returns 0.
- When rs, rt and rd alias, operands are read before the write takes effect.

Test Plan:
(Defaults, NREG=16.)
1. LOADI: step in=0x4C00, then 0x5678, then 0x1234 -> one wr_en_o pulse; r3=0x12345678; out shows 0x5678, after the next step 0x1234, after the next step 1 with state_o=0.
2. ADD: load r1=5 and r2=0xFFFFFFFD; step CMD 0x0490, then FN 0x0000 -> r4=2; out shows 0x0002 then 0x0000.
3. SRA: with r2=0xFFFFFFFD, step CMD 0x0814, then FN 0x8001 -> r5=0xFFFFFFFE; out shows 0xFFFE then 0xFFFF.
4. r0 guard: ADD r1+r2 into rd=0 (CMD 0x0480) -> SHOW displays 2; then READ 0x8000 -> out 0x0000, 0x0000.
5. Reset mid-op: assert reset while in FN with btn held high -> state_o=0, out=1; after release, no step occurs until btn falls and rises; READ r1 returns 0.
6. Reserved/held btn: in=0xC000 -> err=1, state stays CMD; btn held 10 cycles -> exactly one step; err stays 1 until reset.
